oled_spi_receiver: RTL and testbench

//  SPI-slave model of the PmodOLEDrgb (SSD1331) display end of the OLED SPI link. Oversamples SCLK/MOSI/CS_N/DC
//  on the system clock, assembles bytes and decodes the command stream. Pixel bytes become RGB565 framebuffer writes.

---
 rtl/oled_spi_receiver.sv | 246 ++++++++++++++++++++++++
 tb/tb_oled_spi_receiver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_receiver.sv
// SPI-slave model of the SSD1331 end of the OLED link: oversamples the SPI pins,
// assembles bytes and turns the command/pixel stream into RGB565 framebuffer writes.
module oled_spi_receiver #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int AW     = 13
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          sclk_i,
  input  logic          mosi_i,
  input  logic          cs_n_i,
  input  logic          dc_i,
  input  logic          res_i,
  output logic          byte_valid_o,
  output logic [7:0]    byte_o,
  output logic          byte_dc_o,
  output logic          fb_we_o,
  output logic [AW-1:0] fb_addr_o,
  output logic [15:0]   fb_wdata_o,
  output logic          disp_on_o,
  output logic          frame_done_o,
  output logic          err_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  typedef enum logic {P_CMD, P_ARG} parse_state_t;
  typedef enum logic [1:0] {K_COL, K_ROW, K_SKIP} arg_kind_t;

  logic [1:0] sclk_sync, mosi_sync, cs_sync, dc_sync, res_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_s, mosi_s, cs_s, dc_s, res_s, sclk_rise;

  logic [2:0] bit_cnt;
  logic [6:0] sreg;

  parse_state_t  state;
  arg_kind_t     arg_kind;
  logic [1:0]    arg_cnt;
  logic [7:0]    arg_first;
  logic [CW-1:0] col_start, col_end, col;
  logic [RW-1:0] row_start, row_end, row;
  logic          lo_next;
  logic [7:0]    hi_byte;
  logic [AW-1:0] pix_addr;
  logic          at_end;

  function automatic logic [CW-1:0] clamp_col(input logic [7:0] v);
    if (int'(v) > WIDTH - 1) clamp_col = COL_MAX;
    else                     clamp_col = CW'(v);
  endfunction

  function automatic logic [RW-1:0] clamp_row(input logic [7:0] v);
    if (int'(v) > HEIGHT - 1) clamp_row = ROW_MAX;
    else                      clamp_row = RW'(v);
  endfunction

  function automatic logic is_skip_op(input logic [7:0] op);
    case (op)
      8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1,
      8'hB3, 8'hBB, 8'hBE, 8'h81, 8'h82, 8'h87: is_skip_op = 1'b1;
      default:                                  is_skip_op = 1'b0;
    endcase
  endfunction

  // SCLK, CS_N and RES idle high, so their synchronisers come out of reset high
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_sync <= 2'b11;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      res_sync  <= 2'b11;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      cs_sync   <= {cs_sync[0], cs_n_i};
      dc_sync   <= {dc_sync[0], dc_i};
      res_sync  <= {res_sync[0], res_i};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_s      = cs_sync[1];
  assign dc_s      = dc_sync[1];
  assign res_s     = res_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // An 8th edge arriving together with CS_N rising still completes its byte
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bit_cnt      <= 3'd0;
      sreg         <= 7'd0;
      byte_valid_o <= 1'b0;
      byte_o       <= 8'd0;
      byte_dc_o    <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      if (!res_s) begin
        bit_cnt   <= 3'd0;
        sreg      <= 7'd0;
        byte_o    <= 8'd0;
        byte_dc_o <= 1'b0;
      end else if (sclk_rise && (!cs_s || (!cs_prev && bit_cnt == 3'd7))) begin
        sreg    <= {sreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid_o <= 1'b1;
          byte_o       <= {sreg, mosi_s};
          byte_dc_o    <= dc_s;
        end
      end else if (cs_s) begin
        bit_cnt <= 3'd0;
      end
    end
  end

  assign pix_addr = AW'(row) * AW'(WIDTH) + AW'(col);
  assign at_end   = (col == col_end) && (row == row_end);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= P_CMD;
      arg_kind     <= K_SKIP;
      arg_cnt      <= 2'd0;
      arg_first    <= 8'd0;
      col_start    <= '0;
      col_end      <= COL_MAX;
      row_start    <= '0;
      row_end      <= ROW_MAX;
      col          <= '0;
      row          <= '0;
      lo_next      <= 1'b0;
      hi_byte      <= 8'd0;
      fb_we_o      <= 1'b0;
      fb_addr_o    <= '0;
      fb_wdata_o   <= 16'd0;
      disp_on_o    <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      fb_we_o      <= 1'b0;
      frame_done_o <= 1'b0;
      if (!res_s) begin
        state      <= P_CMD;
        arg_kind   <= K_SKIP;
        arg_cnt    <= 2'd0;
        arg_first  <= 8'd0;
        col_start  <= '0;
        col_end    <= COL_MAX;
        row_start  <= '0;
        row_end    <= ROW_MAX;
        col        <= '0;
        row        <= '0;
        lo_next    <= 1'b0;
        hi_byte    <= 8'd0;
        fb_addr_o  <= '0;
        fb_wdata_o <= 16'd0;
        disp_on_o  <= 1'b0;
        err_o      <= 1'b0;
      end else if (byte_valid_o) begin
        if (byte_dc_o) begin
          // A pixel byte mid-argument aborts the command, then is used as pixel data
          if (state == P_ARG) begin
            err_o   <= 1'b1;
            state   <= P_CMD;
            arg_cnt <= 2'd0;
          end
          if (!lo_next) begin
            hi_byte <= byte_o;
            lo_next <= 1'b1;
          end else begin
            lo_next      <= 1'b0;
            fb_we_o      <= 1'b1;
            fb_wdata_o   <= {hi_byte, byte_o};
            fb_addr_o    <= pix_addr;
            frame_done_o <= at_end;
            if (col == col_end) begin
              col <= col_start;
              row <= (row == row_end) ? row_start : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end else begin
          lo_next <= 1'b0;
          if (state == P_CMD) begin
            case (byte_o)
              8'hAE: disp_on_o <= 1'b0;
              8'hAF: disp_on_o <= 1'b1;
              8'h15: begin
                state    <= P_ARG;
                arg_kind <= K_COL;
                arg_cnt  <= 2'd2;
              end
              8'h75: begin
                state    <= P_ARG;
                arg_kind <= K_ROW;
                arg_cnt  <= 2'd2;
              end
              default: begin
                if (is_skip_op(byte_o)) begin
                  state    <= P_ARG;
                  arg_kind <= K_SKIP;
                  arg_cnt  <= 2'd1;
                end
              end
            endcase
          end else begin
            arg_cnt <= arg_cnt - 2'd1;
            if (arg_cnt == 2'd2) begin
              arg_first <= byte_o;
            end else begin
              state <= P_CMD;
              case (arg_kind)
                K_COL: begin
                  col_start <= clamp_col(arg_first);
                  col_end   <= clamp_col(byte_o);
                  col       <= clamp_col(arg_first);
                  row       <= row_start;
                end
                K_ROW: begin
                  row_start <= clamp_row(arg_first);
                  row_end   <= clamp_row(byte_o);
                  row       <= clamp_row(arg_first);
                  col       <= col_start;
                end
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Randomised scoreboard bench for oled_spi_receiver: a byte-level display model
// predicts received bytes and framebuffer writes; a monitor pops and compares them.
module tb_oled_spi_receiver;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        sclk_i = 1'b1;
  logic        mosi_i = 1'b0;
  logic        cs_n_i = 1'b1;
  logic        dc_i = 1'b0;
  logic        res_i = 1'b1;
  logic        byte_valid_o;
  logic [7:0]  byte_o;
  logic        byte_dc_o;
  logic        fb_we_o;
  logic [12:0] fb_addr_o;
  logic [15:0] fb_wdata_o;
  logic        disp_on_o;
  logic        frame_done_o;
  logic        err_o;

  oled_spi_receiver #(.WIDTH(96), .HEIGHT(64), .AW(13)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
    .cs_n_i(cs_n_i), .dc_i(dc_i), .res_i(res_i),
    .byte_valid_o(byte_valid_o), .byte_o(byte_o), .byte_dc_o(byte_dc_o),
    .fb_we_o(fb_we_o), .fb_addr_o(fb_addr_o), .fb_wdata_o(fb_wdata_o),
    .disp_on_o(disp_on_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int b; int dc;} byte_t;
  typedef struct {int addr; int data; int fd;} wr_t;

  byte_t exp_bytes[$];
  wr_t   exp_writes[$];
  int    checks = 0;
  int    fails = 0;
  int    sclk_half = 4;

  // Display model: window bounds, cursor, pending command and its argument list
  int m_disp, m_err, m_cs, m_ce, m_rs, m_re, m_col, m_row;
  int m_need, m_cmd, m_hi;
  bit m_have_hi;
  int m_args[$];

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_disp = 0; m_err = 0;
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63;
    m_col = 0; m_row = 0;
    m_need = 0; m_cmd = 0; m_have_hi = 0; m_hi = 0;
    m_args.delete();
  endfunction

  function automatic void model_byte(int b, int dc);
    wr_t w;
    exp_bytes.push_back('{b, dc});
    if (dc != 0) begin
      if (m_need > 0) begin
        m_err = 1;
        m_need = 0;
        m_args.delete();
      end
      if (!m_have_hi) begin
        m_hi = b;
        m_have_hi = 1;
      end else begin
        w.addr = m_row * 96 + m_col;
        w.data = m_hi * 256 + b;
        w.fd = (m_col == m_ce && m_row == m_re) ? 1 : 0;
        exp_writes.push_back(w);
        m_have_hi = 0;
        if (m_col == m_ce) begin
          m_col = m_cs;
          m_row = (m_row == m_re) ? m_rs : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end else begin
      m_have_hi = 0;
      if (m_need == 0) begin
        m_cmd = b;
        if (b == 'hAE) m_disp = 0;
        else if (b == 'hAF) m_disp = 1;
        else if (b == 'h15 || b == 'h75) m_need = 2;
        else if (b inside {'hA0, 'hA1, 'hA2, 'hA8, 'hAD, 'hB0, 'hB1, 'hB3, 'hBB, 'hBE, 'h81, 'h82, 'h87})
          m_need = 1;
      end else begin
        m_args.push_back(b);
        m_need--;
        if (m_need == 0) begin
          if (m_cmd == 'h15) begin
            m_cs = min_i(m_args[0], 95); m_ce = min_i(m_args[1], 95);
            m_col = m_cs; m_row = m_rs;
          end else if (m_cmd == 'h75) begin
            m_rs = min_i(m_args[0], 63); m_re = min_i(m_args[1], 63);
            m_row = m_rs; m_col = m_cs;
          end
          m_args.delete();
        end
      end
    end
  endfunction

  function automatic void checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Mode 3: data changes on the falling SCLK edge, DUT samples on the rising edge
  task automatic applyStimulus(input logic [7:0] b, input logic dc);
    cs_n_i = 1'b0;
    dc_i = dc;
    model_byte(int'(b), int'(dc));
    for (int i = 7; i >= 0; i--) begin
      sclk_i = 1'b0;
      mosi_i = b[i];
      wait_clks(sclk_half);
      sclk_i = 1'b1;
      wait_clks(sclk_half);
    end
    wait_clks(4);
    checkOutput("disp_on", int'(disp_on_o), m_disp);
    checkOutput("err", int'(err_o), m_err);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    cs_n_i = 1'b0;
    dc_i = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk_i = 1'b0;
      mosi_i = b[i];
      wait_clks(sclk_half);
      sclk_i = 1'b1;
      wait_clks(sclk_half);
    end
    cs_n_i = 1'b1;
    wait_clks(8);
  endtask

  task automatic send_window(input int c0, input int c1, input int r0, input int r1);
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'(c0), 1'b0);
    applyStimulus(8'(c1), 1'b0);
    applyStimulus(8'h75, 1'b0);
    applyStimulus(8'(r0), 1'b0);
    applyStimulus(8'(r1), 1'b0);
  endtask

  task automatic send_pixel(input logic [15:0] px);
    applyStimulus(px[15:8], 1'b1);
    applyStimulus(px[7:0], 1'b1);
  endtask

  // Monitor: every DUT output event is matched against the head of its queue
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (byte_valid_o) begin
        if (exp_bytes.size() == 0) begin
          checkOutput("unexpected_byte", int'(byte_o), -1);
        end else begin
          byte_t e;
          e = exp_bytes.pop_front();
          checkOutput("byte", int'(byte_o), e.b);
          checkOutput("byte_dc", int'(byte_dc_o), e.dc);
        end
      end
      if (fb_we_o) begin
        if (exp_writes.size() == 0) begin
          checkOutput("unexpected_write", int'(fb_addr_o), -1);
        end else begin
          wr_t w;
          w = exp_writes.pop_front();
          checkOutput("fb_addr", int'(fb_addr_o), w.addr);
          checkOutput("fb_wdata", int'(fb_wdata_o), w.data);
          checkOutput("frame_done", int'(frame_done_o), w.fd);
        end
      end else if (frame_done_o) begin
        checkOutput("frame_done_without_we", 1, 0);
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [7:0] ops [15];
    ops = '{8'hAE, 8'hAF, 8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0,
            8'hB3, 8'hBB, 8'h81, 8'h87, 8'h00, 8'h2E, 8'hE3};
    model_reset();
    wait_clks(3);
    checkOutput("rst_byte_valid", int'(byte_valid_o), 0);
    checkOutput("rst_byte", int'(byte_o), 0);
    checkOutput("rst_fb_we", int'(fb_we_o), 0);
    checkOutput("rst_fb_addr", int'(fb_addr_o), 0);
    checkOutput("rst_fb_wdata", int'(fb_wdata_o), 0);
    checkOutput("rst_disp_on", int'(disp_on_o), 0);
    checkOutput("rst_err", int'(err_o), 0);
    rstn_i = 1'b1;
    wait_clks(4);

    $display("[TB] display on at SCLK = clk/8");
    sclk_half = 4;
    applyStimulus(8'hAF, 1'b0);
    sclk_half = 2;

    $display("[TB] full window, first pixels then frame end");
    send_window(8'h00, 8'h5F, 8'h00, 8'h3F);
    for (int i = 0; i < 100; i++) send_pixel(16'hF800);
    send_window(8'h00, 8'h5F, 8'h3E, 8'h3F);
    for (int i = 0; i < 194; i++) send_pixel(16'($urandom));

    $display("[TB] small window with wrap");
    send_window(8'h0A, 8'h0B, 8'h05, 8'h06);
    for (int i = 0; i < 5; i++) send_pixel(16'($urandom));

    $display("[TB] partial byte dropped by CS_N");
    send_partial(8'hAF, 5);
    applyStimulus(8'hAE, 1'b0);

    $display("[TB] argument aborted by pixel data");
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'hAB, 1'b1);
    applyStimulus(8'hCD, 1'b1);
    send_pixel(16'($urandom));

    $display("[TB] random command/pixel mix");
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        int k;
        k = $urandom_range(0, 14);
        applyStimulus(ops[k], 1'b0);
        if (ops[k] inside {8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB3, 8'hBB, 8'h81, 8'h87})
          applyStimulus(8'($urandom), 1'b0);
      end else if (kind == 1) begin
        int a, b, c, d;
        a = $urandom_range(0, 255); b = $urandom_range(a, 255);
        c = $urandom_range(0, 255); d = $urandom_range(c, 255);
        send_window(a, b, c, d);
      end else begin
        send_pixel(16'($urandom));
      end
    end

    $display("[TB] RES pin reset");
    res_i = 1'b0;
    wait_clks(5);
    model_reset();
    res_i = 1'b1;
    wait_clks(4);
    checkOutput("res_disp_on", int'(disp_on_o), 0);
    checkOutput("res_err", int'(err_o), 0);
    send_pixel(16'h1234);

    $display("[TB] async reset mid-pixel");
    applyStimulus(8'hAF, 1'b0);
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'hAB, 1'b1);
    applyStimulus(8'h77, 1'b1);
    rstn_i = 1'b0;
    wait_clks(3);
    model_reset();
    checkOutput("rstn_fb_addr", int'(fb_addr_o), 0);
    checkOutput("rstn_fb_wdata", int'(fb_wdata_o), 0);
    checkOutput("rstn_byte", int'(byte_o), 0);
    checkOutput("rstn_disp_on", int'(disp_on_o), 0);
    checkOutput("rstn_err", int'(err_o), 0);
    rstn_i = 1'b1;
    wait_clks(4);
    send_pixel(16'h5A3C);

    wait_clks(20);
    checkOutput("bytes_left", exp_bytes.size(), 0);
    checkOutput("writes_left", exp_writes.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
